sc_matrix_tx: RTL and testbench

- Read-out end of the Frogger row registers. Snapshots the 8 row buses that describe the game board.
- Serializes the snapshot to a MAX7219-style 8x8 LED matrix driver as one 16-bit word per row: DIN, SCLK and LOAD (chip-select) lines.
- Sits between the game datapath (row registers) and the board's matrix connector. Started by the game FSM once per display refresh.

---
 rtl/sc_matrix_tx.sv | 168 ++++++++++++++++
 tb/tb_sc_matrix_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_matrix_tx.sv
// Frogger board read-out: snapshots the row buses and shifts them to a MAX7219-style
// 8x8 driver, one {4'b0, addr=row+1, row byte} word per row, each closed by a LOAD rise.
module sc_matrix_tx #(
  parameter int DATAWIDTH = 8,
  parameter int ROWS      = 8,
  parameter int CLKDIV    = 4
) (
  input  logic                      SC_MatrixTX_CLOCK_50,
  input  logic                      SC_MatrixTX_RESET_InLow,
  input  logic                      SC_MatrixTX_start_InLow,
  input  logic [ROWS*DATAWIDTH-1:0] SC_MatrixTX_rows_InBUS,
  output logic                      SC_MatrixTX_din_Out,
  output logic                      SC_MatrixTX_sclk_Out,
  output logic                      SC_MatrixTX_load_Out,
  output logic                      SC_MatrixTX_busy_Out,
  output logic                      SC_MatrixTX_done_Out
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_LATCH,
    S_DONE
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [ROWS*DATAWIDTH-1:0] r_frame, w_frame_nxt;
  logic [RW-1:0]             r_row, w_row_nxt;
  logic [3:0]                r_bitcnt, w_bitcnt_nxt;
  logic [CW-1:0]             r_div, w_div_nxt;
  logic [15:0]               r_shreg, w_shreg_nxt;
  logic                      r_din, w_din_nxt;
  logic                      r_sclk, w_sclk_nxt;
  logic                      r_load, w_load_nxt;
  logic                      r_busy, w_busy_nxt;
  logic                      r_done, w_done_nxt;

  logic                      w_div_last;
  logic [DATAWIDTH-1:0]      w_row_data;
  logic [3:0]                w_addr;

  assign w_div_last = (r_div == CW'(CLKDIV - 1));
  assign w_row_data = r_frame[r_row*DATAWIDTH +: DATAWIDTH];
  assign w_addr     = 4'(r_row) + 4'd1;

  always_comb begin
    // NOTE: every next-value is defaulted first so no path leaves one unassigned (no latches).
    w_state_nxt  = r_state;
    w_frame_nxt  = r_frame;
    w_row_nxt    = r_row;
    w_bitcnt_nxt = r_bitcnt;
    w_shreg_nxt  = r_shreg;
    w_div_nxt    = '0;
    w_load_nxt   = r_load;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_load_nxt = 1'b1;
        w_busy_nxt = 1'b0;
        if (!SC_MatrixTX_start_InLow) begin
          w_frame_nxt = SC_MatrixTX_rows_InBUS;
          w_row_nxt   = '0;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_shreg_nxt  = {4'b0000, w_addr, w_row_data};
        w_bitcnt_nxt = 4'd15;
        w_load_nxt   = 1'b0;
        w_busy_nxt   = 1'b1;
        w_state_nxt  = S_LOW;
      end
      S_LOW: begin
        w_div_nxt = r_div + CW'(1);
        if (w_div_last) begin
          w_div_nxt   = '0;
          w_state_nxt = S_HIGH;
        end
      end
      S_HIGH: begin
        w_div_nxt = r_div + CW'(1);
        if (w_div_last) begin
          w_div_nxt   = '0;
          w_shreg_nxt = {r_shreg[14:0], 1'b0};
          if (r_bitcnt == 4'd0) begin
            w_state_nxt = S_LATCH;
          end else begin
            w_bitcnt_nxt = r_bitcnt - 4'd1;
            w_state_nxt  = S_LOW;
          end
        end
      end
      S_LATCH: begin
        w_div_nxt = r_div + CW'(1);
        if (w_div_last) begin
          w_div_nxt  = '0;
          w_load_nxt = 1'b1;
          if (r_row == RW'(ROWS - 1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_row_nxt   = r_row + RW'(1);
            w_state_nxt = S_SETUP;
          end
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_load_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // SCLK and DIN track the state being entered, so each LOW/HIGH phase lasts exactly
    // CLKDIV cycles on the pins and LOAD rises CLKDIV cycles after the last SCLK fall.
    w_sclk_nxt = (w_state_nxt == S_HIGH);
    case (w_state_nxt)
      S_LOW:   w_din_nxt = w_shreg_nxt[15];
      S_HIGH:  w_din_nxt = r_din;
      default: w_din_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge SC_MatrixTX_CLOCK_50 or negedge SC_MatrixTX_RESET_InLow) begin
    if (!SC_MatrixTX_RESET_InLow) begin
      r_state  <= S_IDLE;
      // NOTE: the frame snapshot is a plain flop bank, not a RAM, so it takes the reset too.
      r_frame  <= '0;
      r_row    <= '0;
      r_bitcnt <= 4'd15;
      r_div    <= '0;
      r_shreg  <= '0;
      r_din    <= 1'b0;
      r_sclk   <= 1'b0;
      r_load   <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every flop samples the pre-edge values.
      r_state  <= w_state_nxt;
      r_frame  <= w_frame_nxt;
      r_row    <= w_row_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_div    <= w_div_nxt;
      r_shreg  <= w_shreg_nxt;
      r_din    <= w_din_nxt;
      r_sclk   <= w_sclk_nxt;
      r_load   <= w_load_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign SC_MatrixTX_din_Out  = r_din;
  assign SC_MatrixTX_sclk_Out = r_sclk;
  assign SC_MatrixTX_load_Out = r_load;
  assign SC_MatrixTX_busy_Out = r_busy;
  assign SC_MatrixTX_done_Out = r_done;

endmodule

// File: tb/tb_sc_matrix_tx.sv
// Bench for sc_matrix_tx: default instance (a) and a CLKDIV=1/ROWS=3 instance (b).
// Expected words are queued when a frame is started and popped on each LOAD rise.
module tb_sc_matrix_tx;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        start_a = 1'b1;
  logic        start_b = 1'b1;
  logic [63:0] rows_a  = '0;
  logic [23:0] rows_b  = '0;

  logic din_a, sclk_a, load_a, busy_a, done_a;
  logic din_b, sclk_b, load_b, busy_b, done_b;
  logic [1:0] m_din, m_sclk, m_load, m_busy, m_done;

  assign m_din  = {din_b, din_a};
  assign m_sclk = {sclk_b, sclk_a};
  assign m_load = {load_b, load_a};
  assign m_busy = {busy_b, busy_a};
  assign m_done = {done_b, done_a};

  sc_matrix_tx #(.DATAWIDTH(8), .ROWS(8), .CLKDIV(4)) u_dut_a (
    .SC_MatrixTX_CLOCK_50   (clk),
    .SC_MatrixTX_RESET_InLow(rst_n),
    .SC_MatrixTX_start_InLow(start_a),
    .SC_MatrixTX_rows_InBUS (rows_a),
    .SC_MatrixTX_din_Out    (din_a),
    .SC_MatrixTX_sclk_Out   (sclk_a),
    .SC_MatrixTX_load_Out   (load_a),
    .SC_MatrixTX_busy_Out   (busy_a),
    .SC_MatrixTX_done_Out   (done_a)
  );

  sc_matrix_tx #(.DATAWIDTH(8), .ROWS(3), .CLKDIV(1)) u_dut_b (
    .SC_MatrixTX_CLOCK_50   (clk),
    .SC_MatrixTX_RESET_InLow(rst_n),
    .SC_MatrixTX_start_InLow(start_b),
    .SC_MatrixTX_rows_InBUS (rows_b),
    .SC_MatrixTX_din_Out    (din_b),
    .SC_MatrixTX_sclk_Out   (sclk_b),
    .SC_MatrixTX_load_Out   (load_b),
    .SC_MatrixTX_busy_Out   (busy_b),
    .SC_MatrixTX_done_Out   (done_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];

  function automatic logic [15:0] word(input int r, input logic [7:0] d);
    return {4'h0, 4'(r + 1), d};
  endfunction

  task automatic push_frame(input int k, input logic [63:0] rows, input int nrows);
    for (int r = 0; r < nrows; r++) begin
      if (k == 0) q_a.push_back(word(r, rows[r*8 +: 8]));
      else        q_b.push_back(word(r, rows[r*8 +: 8]));
    end
  endtask

  // Monitor state, sampled on the falling clock edge
  int          cyc = 0;
  int          sclk_rises[2] = '{0, 0};
  int          load_rises[2] = '{0, 0};
  int          cap_bits[2]   = '{0, 0};
  int          last_rise[2]  = '{0, 0};
  int          per_min[2]    = '{1000000, 1000000};
  int          per_max[2]    = '{0, 0};
  logic [15:0] cap[2];
  logic [1:0]  prev_sclk = 2'b00;
  logic [1:0]  prev_load = 2'b11;

  task automatic word_done(input int k);
    logic [15:0] e;
    string sfx;
    sfx = (k == 0) ? "a" : "b";
    check($sformatf("bits_per_word_%s", sfx), cap_bits[k], 16);
    if (k == 0) begin
      check("word_pending_a", q_a.size() != 0, 1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("word_a", cap[0], e);
      end
    end else begin
      check("word_pending_b", q_b.size() != 0, 1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check("word_b", cap[1], e);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          cap_bits[k] = 0;
        end else begin
          if (m_sclk[k] && !prev_sclk[k]) begin
            if (cap_bits[k] > 0) begin
              if (cyc - last_rise[k] < per_min[k]) per_min[k] = cyc - last_rise[k];
              if (cyc - last_rise[k] > per_max[k]) per_max[k] = cyc - last_rise[k];
            end
            last_rise[k] = cyc;
            cap[k]       = {cap[k][14:0], m_din[k]};
            cap_bits[k]++;
            sclk_rises[k]++;
          end
          if (m_load[k] && !prev_load[k]) begin
            load_rises[k]++;
            word_done(k);
            cap_bits[k] = 0;
          end
        end
        prev_sclk[k] = m_sclk[k];
        prev_load[k] = m_load[k];
      end
    end
  end

  task automatic set_start(input int k, input logic v);
    if (k == 0) start_a = v;
    else        start_b = v;
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk);
    set_start(k, 1'b0);
    @(negedge clk);
    set_start(k, 1'b1);
  endtask

  // Counts busy-high cycles (bounded); optionally pokes start at busy cycle poke_at
  // and holds it low from busy cycle hold_from onward.
  task automatic wait_frame(input int k, input int exp_busy, input int poke_at,
                            input int hold_from);
    int    n;
    int    cnt;
    string sfx;
    sfx = (k == 0) ? "a" : "b";
    n   = 0;
    cnt = 0;
    while (!m_busy[k] && n < 10) begin
      @(negedge clk);
      n++;
    end
    while (m_busy[k] && cnt < 3000) begin
      if (poke_at >= 0 && cnt == poke_at)     set_start(k, 1'b0);
      if (poke_at >= 0 && cnt == poke_at + 1) set_start(k, 1'b1);
      if (hold_from >= 0 && cnt == hold_from) set_start(k, 1'b0);
      cnt++;
      @(negedge clk);
    end
    check($sformatf("busy_len_%s", sfx), cnt, exp_busy);
    check($sformatf("done_pulse_%s", sfx), m_done[k], 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int sbase;
    int n;

    // Power-on reset
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs_a", {din_a, sclk_a, load_a, busy_a, done_a}, 5'b00100);
    check("rst_outs_b", {din_b, sclk_b, load_b, busy_b, done_b}, 5'b00100);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_outs_a", {din_a, sclk_a, load_a, busy_a, done_a}, 5'b00100);

    // Single frame, row0 = A5
    rows_a = 64'h0000_0000_0000_00A5;
    push_frame(0, rows_a, 8);
    base  = load_rises[0];
    sbase = sclk_rises[0];
    pulse_start(0);
    wait_frame(0, 1064, -1, -1);
    @(negedge clk);
    check("done_clear_a", {done_a, busy_a}, 2'b00);
    repeat (6) @(negedge clk);
    check("load_rises_a", load_rises[0] - base, 8);
    check("sclk_rises_a", sclk_rises[0] - sbase, 128);
    check("queue_empty_a1", q_a.size(), 0);

    // Snapshot: rows cleared one cycle after start
    rows_a = 64'hFFFF_FFFF_FFFF_FFFF;
    push_frame(0, rows_a, 8);
    pulse_start(0);
    rows_a = '0;
    wait_frame(0, 1064, -1, -1);
    repeat (6) @(negedge clk);
    check("queue_empty_a2", q_a.size(), 0);

    // Start pulse mid-frame ignored; start held low gives a back-to-back frame
    rows_a = 64'h0102_0408_1020_4080;
    push_frame(0, rows_a, 8);
    pulse_start(0);
    rows_a = 64'h8877_6655_4433_2211;
    push_frame(0, rows_a, 8);
    wait_frame(0, 1064, 300, 1060);
    @(negedge clk);
    check("b2b_setup_busy_low", busy_a, 0);
    @(negedge clk);
    check("b2b_busy_rise", busy_a, 1);
    start_a = 1'b1;
    wait_frame(0, 1064, -1, -1);
    repeat (6) @(negedge clk);
    check("queue_empty_a3", q_a.size(), 0);

    // Reset during bit 6 of row 3
    rows_a = 64'hC3C3_C3C3_C3C3_C3C3;
    push_frame(0, rows_a, 8);
    base = load_rises[0];
    pulse_start(0);
    n = 0;
    while (!((load_rises[0] - base == 3) && (cap_bits[0] == 6)) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reach_row3_bit6", n < 5000, 1);
    check("pre_rst_busy_load", {busy_a, load_a}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_a", {din_a, sclk_a, load_a, busy_a, done_a}, 5'b00100);
    repeat (4) begin
      @(negedge clk);
      check("rst_hold_a", {din_a, sclk_a, load_a, busy_a, done_a}, 5'b00100);
    end
    check("aborted_pending", q_a.size(), 5);
    q_a.delete();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_partial_load", load_rises[0] - base, 3);
    check("idle_after_rst", {din_a, sclk_a, load_a, busy_a, done_a}, 5'b00100);
    rows_a = 64'h1E2D_3C4B_5A69_7887;
    push_frame(0, rows_a, 8);
    pulse_start(0);
    wait_frame(0, 1064, -1, -1);
    repeat (6) @(negedge clk);
    check("queue_empty_a4", q_a.size(), 0);

    // CLKDIV=1, ROWS=3 instance
    rows_b = 24'h3C_C3_81;
    push_frame(1, {40'h0, rows_b}, 3);
    base  = load_rises[1];
    sbase = sclk_rises[1];
    pulse_start(1);
    wait_frame(1, 102, -1, -1);
    @(negedge clk);
    check("done_clear_b", {done_b, busy_b}, 2'b00);
    repeat (4) @(negedge clk);
    check("load_rises_b", load_rises[1] - base, 3);
    check("sclk_rises_b", sclk_rises[1] - sbase, 48);
    check("queue_empty_b", q_b.size(), 0);

    check("sclk_period_min_a", per_min[0], 8);
    check("sclk_period_max_a", per_max[0], 8);
    check("sclk_period_min_b", per_min[1], 2);
    check("sclk_period_max_b", per_max[1], 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
